// File: rtl/life_array_grid_if.sv
// Control, edge-neighbour and status bundle for the life_array_grid cell array.
interface life_array_grid_if #(
  parameter int unsigned ROWS  = 8,
  parameter int unsigned COLS  = 8,
  parameter int unsigned GEN_W = 16
);
  logic [ROWS*COLS-1:0] val;
  logic                 write_enb;
  logic                 step;
  logic [COLS-1:0]      n;
  logic [COLS-1:0]      s;
  logic [ROWS-1:0]      w;
  logic [ROWS-1:0]      e;
  logic                 nw;
  logic                 ne;
  logic                 se;
  logic                 sw;
  logic [ROWS*COLS-1:0] alive;
  logic [GEN_W-1:0]     generation;
  logic                 extinct;
  logic                 still;
  logic                 period2;

  modport master (
    output val, write_enb, step, n, s, w, e, nw, ne, se, sw,
    input  alive, generation, extinct, still, period2
  );

  modport slave (
    input  val, write_enb, step, n, s, w, e, nw, ne, se, sw,
    output alive, generation, extinct, still, period2
  );
endinterface

// File: rtl/life_array_grid.sv
// ROWS x COLS synchronous Game-of-Life grid with parallel load, edge-triggered
// single-generation stepping, edge-port or toroidal boundary, and status flags.
module life_array_grid #(
  parameter int unsigned ROWS  = 8,
  parameter int unsigned COLS  = 8,
  parameter int unsigned WRAP  = 0,
  parameter int unsigned GEN_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  life_array_grid_if.slave     bus
);
  localparam int unsigned CELLS = ROWS * COLS;

  logic [CELLS-1:0] alive_q;
  logic [CELLS-1:0] prev1_q;
  logic [GEN_W-1:0] gen_q;
  logic             extinct_q;
  logic             still_q;
  logic             period2_q;
  logic             step_q;

  logic             step_edge;
  logic [CELLS-1:0] next_grid;
  logic             pad [ROWS+2][COLS+2];
  logic [3:0]       cnt;

  assign step_edge = bus.step & ~step_q;

  // Grid framed by one ring of neighbour sources, then the per-cell rule.
  always_comb begin
    for (int unsigned r = 0; r < ROWS + 2; r++) begin
      for (int unsigned c = 0; c < COLS + 2; c++) begin
        pad[r][c] = 1'b0;
      end
    end
    next_grid = '0;
    cnt       = '0;

    for (int unsigned r = 0; r < ROWS; r++) begin
      for (int unsigned c = 0; c < COLS; c++) begin
        pad[r+1][c+1] = alive_q[COLS*r+c];
      end
    end

    for (int unsigned c = 0; c < COLS; c++) begin
      pad[0][c+1]      = (WRAP != 0) ? alive_q[COLS*(ROWS-1)+c] : bus.n[c];
      pad[ROWS+1][c+1] = (WRAP != 0) ? alive_q[c]               : bus.s[c];
    end
    for (int unsigned r = 0; r < ROWS; r++) begin
      pad[r+1][0]      = (WRAP != 0) ? alive_q[COLS*r+COLS-1] : bus.w[r];
      pad[r+1][COLS+1] = (WRAP != 0) ? alive_q[COLS*r]        : bus.e[r];
    end
    pad[0][0]           = (WRAP != 0) ? alive_q[CELLS-1]         : bus.nw;
    pad[0][COLS+1]      = (WRAP != 0) ? alive_q[COLS*(ROWS-1)]   : bus.ne;
    pad[ROWS+1][0]      = (WRAP != 0) ? alive_q[COLS-1]          : bus.sw;
    pad[ROWS+1][COLS+1] = (WRAP != 0) ? alive_q[0]               : bus.se;

    for (int unsigned r = 0; r < ROWS; r++) begin
      for (int unsigned c = 0; c < COLS; c++) begin
        cnt = '0;
        for (int unsigned i = 0; i < 3; i++) begin
          for (int unsigned j = 0; j < 3; j++) begin
            if (!(i == 1 && j == 1)) begin
              cnt = cnt + 4'(pad[r+i][c+j]);
            end
          end
        end
        next_grid[COLS*r+c] = (cnt == 4'd3) | (alive_q[COLS*r+c] & (cnt == 4'd2));
      end
    end
  end

  // Priority: reset, then load, then a single step per rising edge of step.
  always_ff @(posedge clk) begin
    if (reset) begin
      alive_q   <= '0;
      prev1_q   <= '0;
      gen_q     <= '0;
      extinct_q <= 1'b1;
      still_q   <= 1'b0;
      period2_q <= 1'b0;
      step_q    <= 1'b1;
    end else begin
      step_q <= bus.step;
      if (bus.write_enb) begin
        alive_q   <= bus.val;
        prev1_q   <= bus.val;
        gen_q     <= '0;
        extinct_q <= (bus.val == '0);
        still_q   <= 1'b0;
        period2_q <= 1'b0;
      end else if (step_edge) begin
        alive_q   <= next_grid;
        prev1_q   <= alive_q;
        gen_q     <= gen_q + GEN_W'(1);
        extinct_q <= (next_grid == '0);
        still_q   <= (next_grid == alive_q);
        period2_q <= (next_grid == prev1_q) & (next_grid != alive_q);
      end
    end
  end

  assign bus.alive      = alive_q;
  assign bus.generation = gen_q;
  assign bus.extinct    = extinct_q;
  assign bus.still      = still_q;
  assign bus.period2    = period2_q;
endmodule

// File: tb/tb_life_array_grid.sv
// Directed bench: three 4x4 grids (edge ports, toroidal, 2-bit generation
// counter) share one stimulus stream and are checked against hand-computed values.
module tb_life_array_grid;
  logic clk;
  logic reset;

  logic [15:0] val;
  logic        write_enb;
  logic        step;
  logic [3:0]  n, s, w, e;
  logic        nw, ne, se, sw;

  int checks;
  int errors;

  life_array_grid_if #(.ROWS(4), .COLS(4), .GEN_W(16)) bus_a ();
  life_array_grid_if #(.ROWS(4), .COLS(4), .GEN_W(16)) bus_b ();
  life_array_grid_if #(.ROWS(4), .COLS(4), .GEN_W(2))  bus_c ();

  assign bus_a.val = val;  assign bus_a.write_enb = write_enb;  assign bus_a.step = step;
  assign bus_a.n = n;  assign bus_a.s = s;  assign bus_a.w = w;  assign bus_a.e = e;
  assign bus_a.nw = nw;  assign bus_a.ne = ne;  assign bus_a.se = se;  assign bus_a.sw = sw;

  assign bus_b.val = val;  assign bus_b.write_enb = write_enb;  assign bus_b.step = step;
  assign bus_b.n = n;  assign bus_b.s = s;  assign bus_b.w = w;  assign bus_b.e = e;
  assign bus_b.nw = nw;  assign bus_b.ne = ne;  assign bus_b.se = se;  assign bus_b.sw = sw;

  assign bus_c.val = val;  assign bus_c.write_enb = write_enb;  assign bus_c.step = step;
  assign bus_c.n = n;  assign bus_c.s = s;  assign bus_c.w = w;  assign bus_c.e = e;
  assign bus_c.nw = nw;  assign bus_c.ne = ne;  assign bus_c.se = se;  assign bus_c.sw = sw;

  life_array_grid #(.ROWS(4), .COLS(4), .WRAP(0), .GEN_W(16)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a));
  life_array_grid #(.ROWS(4), .COLS(4), .WRAP(1), .GEN_W(16)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b));
  life_array_grid #(.ROWS(4), .COLS(4), .WRAP(0), .GEN_W(2)) dut_c (
    .clk(clk), .reset(reset), .bus(bus_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [15:0] v);
    val       = v;
    write_enb = 1'b1;
    tick();
    write_enb = 1'b0;
  endtask

  task automatic do_step();
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;  val = '0;  write_enb = 1'b0;  step = 1'b0;
    n = '0;  s = '0;  w = '0;  e = '0;  nw = 1'b0;  ne = 1'b0;  se = 1'b0;  sw = 1'b0;
    tick();
    tick();
    chk("rst_alive",   32'(bus_a.alive), 32'h0);
    chk("rst_gen",     32'(bus_a.generation), 32'h0);
    chk("rst_extinct", 32'(bus_a.extinct), 32'h1);
    chk("rst_still",   32'(bus_a.still), 32'h0);
    chk("rst_period2", 32'(bus_a.period2), 32'h0);
    reset = 1'b0;
    tick();

    // Blinker, step held high for two cycles
    do_load(16'h0070);
    chk("blk_load",    32'(bus_a.alive), 32'h0070);
    chk("blk_load_ex", 32'(bus_a.extinct), 32'h0);
    step = 1'b1;
    tick();
    chk("blk_step1", 32'(bus_a.alive), 32'h0222);
    tick();
    chk("blk_hold",    32'(bus_a.alive), 32'h0222);
    chk("blk_gen",     32'(bus_a.generation), 32'h1);
    chk("blk_still",   32'(bus_a.still), 32'h0);
    chk("blk_period2", 32'(bus_a.period2), 32'h0);
    step = 1'b0;
    tick();

    // Beacon oscillator
    do_load(16'hCC33);
    chk("bcn_gen0", 32'(bus_a.generation), 32'h0);
    do_step();
    chk("bcn_step1", 32'(bus_a.alive), 32'hC813);
    chk("bcn_p2_1",  32'(bus_a.period2), 32'h0);
    do_step();
    chk("bcn_step2",   32'(bus_a.alive), 32'hCC33);
    chk("bcn_gen",     32'(bus_a.generation), 32'h2);
    chk("bcn_period2", 32'(bus_a.period2), 32'h1);
    chk("bcn_still",   32'(bus_a.still), 32'h0);

    // Block still life, then lone cell dies
    do_load(16'h0660);
    do_step();
    chk("blkl_alive",   32'(bus_a.alive), 32'h0660);
    chk("blkl_still",   32'(bus_a.still), 32'h1);
    chk("blkl_extinct", 32'(bus_a.extinct), 32'h0);
    do_load(16'h0001);
    do_step();
    chk("lone_alive",   32'(bus_a.alive), 32'h0);
    chk("lone_extinct", 32'(bus_a.extinct), 32'h1);
    chk("lone_gen",     32'(bus_a.generation), 32'h1);

    // Birth from edge ports; toroidal grid ignores them
    n = 4'b0001;  w = 4'b0001;  nw = 1'b1;
    do_load(16'h0000);
    do_step();
    chk("edge_nowrap", 32'(bus_a.alive), 32'h0001);
    chk("edge_wrap",   32'(bus_b.alive), 32'h0000);
    n = '0;  w = '0;  nw = 1'b0;

    // Blinker across the wrap seam
    do_load(16'h000B);
    do_step();
    chk("seam_wrap",   32'(bus_b.alive), 32'h1011);
    chk("seam_nowrap", 32'(bus_a.alive), 32'h0000);

    // Load and step rising together: load wins, step discarded
    val = 16'h0070;  write_enb = 1'b1;  step = 1'b1;
    tick();
    chk("ld_step_alive", 32'(bus_a.alive), 32'h0070);
    chk("ld_step_gen",   32'(bus_a.generation), 32'h0);
    write_enb = 1'b0;
    tick();
    tick();
    chk("ld_step_after", 32'(bus_a.alive), 32'h0070);
    chk("ld_step_gen2",  32'(bus_a.generation), 32'h0);
    step = 1'b0;
    tick();

    // Reset mid-run with step held high
    step = 1'b1;
    tick();
    chk("mid_pre_gen", 32'(bus_a.generation), 32'h1);
    reset = 1'b1;
    tick();
    chk("mid_rst_alive",   32'(bus_a.alive), 32'h0);
    chk("mid_rst_gen",     32'(bus_a.generation), 32'h0);
    chk("mid_rst_extinct", 32'(bus_a.extinct), 32'h1);
    reset = 1'b0;
    tick();
    tick();
    chk("mid_post_gen", 32'(bus_a.generation), 32'h0);
    step = 1'b0;
    tick();
    step = 1'b1;
    tick();
    chk("mid_restep_gen", 32'(bus_a.generation), 32'h1);
    step = 1'b0;
    tick();

    // Generation counter wrap with 2-bit width
    do_load(16'h0070);
    for (int k = 0; k < 5; k++) begin
      do_step();
    end
    chk("gen_wrap2", 32'(bus_c.generation), 32'h1);
    chk("gen_full",  32'(bus_a.generation), 32'h5);
    chk("gen_alive", 32'(bus_c.alive), 32'h0222);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/life_array_grid.md
Name: life_array_grid

Overview:
- Parametrised successor to the fixed 4x4 Conway cell array: a ROWS x COLS synchronous Game-of-Life grid with parallel load and single-generation stepping.
- Boundary mode is selectable: external edge inputs for tiling, or internal toroidal wrap.
- Adds a generation counter and registered extinct/still-life/period-2 status flags.
- Sits under the display/control logic and replaces per-size array modules.

Parameters:
ROWS, 8, grid height; >=2 (>=3 when WRAP=1).
COLS, 8, grid width; >=2 (>=3 when WRAP=1).
WRAP, 0, 0 = neighbours outside the grid come from edge ports; 1 = toroidal, edge ports ignored.
GEN_W, 16, generation counter width.

Ports:
clk  in  1  rising-edge clock.
reset  in  1  synchronous, active-high.
val  in  ROWS*COLS  load pattern; bit COLS*r+c = row r (0 = top), column c (0 = left).
write_enb  in  1  level: load val into the grid on every cycle it is high.
step  in  1  advance one generation per 0->1 transition.
n  in  COLS  cells above row 0; n[c] sits above column c.
s  in  COLS  cells below row ROWS-1.
w  in  ROWS  cells left of column 0; w[r] sits beside row r.
e  in  ROWS  cells right of column COLS-1.
nw, ne, se, sw  in  1 each  diagonal corner neighbours.
alive  out  ROWS*COLS  current grid, same bit mapping as val.
generation  out  GEN_W  generations since the last load/reset.
extinct  out  1  alive == 0.
still  out  1  last step produced no change.
period2  out  1  last step reproduced the grid from two generations earlier, and the grid differs from the previous one.

Behaviour:
- State: alive, prev1 (grid one generation back), step_q (registered step), generation, flags.
- Reset: alive=0, prev1=0, generation=0, extinct=1, still=0, period2=0, step_q=1.
  - step_q=1 means a step held high through reset does not fire after reset releases.
- step_edge = step & ~step_q. step_q <= step every cycle.
- Priority on each rising clk: reset > write_enb > step_edge.
- Load (write_enb=1):
  - alive <= val, prev1 <= val, generation <= 0, still <= 0, period2 <= 0.
  - extinct <= (val == 0).
  - A coincident step_edge is discarded, not deferred.
- Step (step_edge and not write_enb):
  - alive <= next, computed from the current alive. Latency is 1 clock; alive shows the new generation after the same edge that samples the 0->1 transition.
  - Holding step high produces no further generations.
  - prev1 <= alive.
  - generation <= generation + 1, wrapping modulo 2^GEN_W.
  - still <= (next == alive).
  - period2 <= (next == prev1) & (next != alive).
  - extinct <= (next == 0).
- Idle cycles: all state holds. Edge inputs may change freely; they are used only at a step.
- Rule per cell: count the 8 neighbours (4-bit count).
  - A live cell survives with 2 or 3 neighbours.
  - A dead cell is born with exactly 3.
  - Otherwise the cell is dead.
- Neighbour sources, WRAP=0:
  - Row -1 -> n[c]; row ROWS -> s[c]; column -1 -> w[r]; column COLS -> e[r].
  - Corner positions -> nw (-1,-1), ne (-1,COLS), sw (ROWS,-1), se (ROWS,COLS).
- Neighbour sources, WRAP=1: row and column indices are taken modulo ROWS/COLS. n/s/e/w and the corner ports are ignored.
- next is computed from alive only, never from partially updated cells; all cells update simultaneously.

Test Plan:
1. ROWS=COLS=4, WRAP=0, edges 0: load 0x0070, release write_enb, raise step for 2 cycles -> alive=0x0222 after the first edge and still 0x0222 after the second. generation=1, still=0, period2=0.
2. Same setup: load 0xCC33, step -> 0xC813. Drop step, step again -> 0xCC33, generation=2, period2=1, still=0.
3. Load 0x0660, step -> alive=0x0660, still=1, extinct=0. Then load 0x0001, step -> alive=0, extinct=1, generation=1.
4. Edges: n=4'b0001, w=4'b0001, nw=1, load 0x0000, step -> alive=0x0001. Same with WRAP=1 -> alive=0x0000.
5. WRAP=1, 4x4, load 0x000B, step -> 0x1011. Same pattern with WRAP=0 and edges 0 -> 0x0000.
6. Boundary cases:
   - write_enb and step rising in the same cycle -> alive=val, generation=0, no step afterwards.
   - reset asserted mid-run with step held high -> all outputs at reset values; no generation after reset releases until step returns to 0 and rises again.
   - GEN_W=2: five steps -> generation=1.
